// File: rtl/stopwatch_counter.sv
// BCD mm:ss stopwatch core: button synchronizers, PAUSED/RUN/ADJUST control,
// 1 Hz run counting and 2 Hz field adjust, feeding the 7-segment scan stage.
module stopwatch_counter #(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tick_1hz,
  input  logic       tick_2hz,
  input  logic       adj,
  input  logic       sel,
  input  logic       pause_btn,
  input  logic       reset_btn,
  output logic [4:0] min_l,
  output logic [4:0] min_r,
  output logic [4:0] sec_l,
  output logic [4:0] sec_r,
  output logic       running
);

  typedef enum logic [1:0] {
    PAUSED = 2'd0,
    RUN    = 2'd1,
    ADJUST = 2'd2
  } state_t;

  logic [SYNC_STAGES-1:0] pause_sync_q, clear_sync_q, fill_q;
  logic                   pause_prev_q, clear_prev_q;
  logic                   pause_arm_q, clear_arm_q;
  logic                   pause_arm_d, clear_arm_d;
  logic                   pause_lvl, clear_lvl;
  logic                   pause_ev, clear_ev;

  logic [7:0] sec_q, sec_d, min_q, min_d;
  state_t     state_q, state_d;
  logic       running_q, running_d;

  // Two-digit BCD increment over 00..59, wrapping to 00.
  function automatic logic [7:0] inc60(input logic [7:0] v);
    if (v[3:0] >= 4'd9)
      return (v[7:4] >= 4'd5) ? 8'h00 : {v[7:4] + 4'd1, 4'd0};
    else
      return {v[7:4], v[3:0] + 4'd1};
  endfunction

  assign pause_lvl = pause_sync_q[SYNC_STAGES-1];
  assign clear_lvl = clear_sync_q[SYNC_STAGES-1];

  // A detector only arms once its synchronized level has been seen low after
  // the synchronizer has refilled, so a button held through reset stays silent.
  always_comb begin
    pause_arm_d = pause_arm_q | (fill_q[SYNC_STAGES-1] & ~pause_lvl);
    clear_arm_d = clear_arm_q | (fill_q[SYNC_STAGES-1] & ~clear_lvl);
    pause_ev    = pause_lvl & ~pause_prev_q & pause_arm_q;
    clear_ev    = clear_lvl & ~clear_prev_q & clear_arm_q;
  end

  always_comb begin
    sec_d = sec_q;
    min_d = min_q;
    if (clear_ev) begin
      sec_d = 8'h00;
      min_d = 8'h00;
    end else if (state_q == RUN && tick_1hz) begin
      sec_d = inc60(sec_q);
      if (sec_q == 8'h59)
        min_d = inc60(min_q);
    end else if (state_q == ADJUST && tick_2hz) begin
      if (sel)
        min_d = inc60(min_q);
      else
        sec_d = inc60(sec_q);
    end
  end

  always_comb begin
    state_d = state_q;
    if (adj)
      state_d = ADJUST;
    else if (state_q == ADJUST)
      state_d = PAUSED;
    else if (clear_ev)
      state_d = PAUSED;
    else if (pause_ev)
      state_d = (state_q == RUN) ? PAUSED : RUN;
    running_d = (state_d == RUN);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pause_sync_q <= '0;
      clear_sync_q <= '0;
      fill_q       <= '0;
      pause_prev_q <= 1'b0;
      clear_prev_q <= 1'b0;
      pause_arm_q  <= 1'b0;
      clear_arm_q  <= 1'b0;
      sec_q        <= 8'h00;
      min_q        <= 8'h00;
      state_q      <= PAUSED;
      running_q    <= 1'b0;
    end else begin
      pause_sync_q <= {pause_sync_q[SYNC_STAGES-2:0], pause_btn};
      clear_sync_q <= {clear_sync_q[SYNC_STAGES-2:0], reset_btn};
      fill_q       <= {fill_q[SYNC_STAGES-2:0], 1'b1};
      pause_prev_q <= pause_lvl;
      clear_prev_q <= clear_lvl;
      pause_arm_q  <= pause_arm_d;
      clear_arm_q  <= clear_arm_d;
      sec_q        <= sec_d;
      min_q        <= min_d;
      state_q      <= state_d;
      running_q    <= running_d;
    end
  end

  assign min_l   = {1'b0, min_q[7:4]};
  assign min_r   = {1'b0, min_q[3:0]};
  assign sec_l   = {1'b0, sec_q[7:4]};
  assign sec_r   = {1'b0, sec_q[3:0]};
  assign running = running_q;

endmodule

// File: doc/stopwatch_counter.md
Name: stopwatch_counter

Overview:
BCD minutes/seconds timekeeper for the stopwatch. It sits directly upstream of the 7-segment scan/display stage and drives its min_l, min_r, sec_l and sec_r digit inputs. It counts on a 1 Hz tick, supports pause/resume and clear from raw push-buttons, and provides a field-adjust mode stepped by a 2 Hz tick.

Parameters:
SYNC_STAGES, 2, number of flip-flop stages in each push-button synchronizer (minimum 2).

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
tick_1hz  input  1  one-clk-wide count-enable pulse from the clock divider
tick_2hz  input  1  one-clk-wide adjust-step pulse from the clock divider
adj  input  1  level; 1 = adjust mode
sel  input  1  adjust field select; 0 = seconds, 1 = minutes
pause_btn  input  1  raw, asynchronous pause/resume button (already debounced)
reset_btn  input  1  raw, asynchronous clear button (already debounced)
min_l  output  5  minutes tens digit, 0-5
min_r  output  5  minutes units digit, 0-9
sec_l  output  5  seconds tens digit, 0-5
sec_r  output  5  seconds units digit, 0-9
running  output  1  1 while in state RUN

Behaviour:
- Reset (rst_n=0, asynchronous):
  - All digits are 0.
  - running=0.
  - FSM is in PAUSED.
  - All synchronizer and edge-detect flops are 0.
- Digit bit 4 is always 0. Each digit holds a value in its stated range at all times.
- Buttons:
  - Each button passes through a SYNC_STAGES-flop synchronizer, then a rising-edge detector that produces a one-clk pulse (pause_ev, clear_ev).
  - A button press appears as an event SYNC_STAGES+1 clks after the input rises.
  - A held button produces exactly one event.
- FSM states: PAUSED, RUN, ADJUST.
  - Any state, adj=1: go to ADJUST.
  - ADJUST, adj=0: go to PAUSED. The stopwatch never resumes running straight out of adjust.
  - PAUSED, pause_ev and adj=0: go to RUN.
  - RUN, pause_ev and adj=0: go to PAUSED.
  - Any state, clear_ev: all digits go to 0. If the state is RUN, go to PAUSED. If the state is ADJUST, stay in ADJUST.
- Counting:
  - Applies only while the registered state is RUN and tick_1hz=1.
  - Digits update on the same clk edge that samples the tick (1-clk latency to the outputs).
  - Carry chain:
    - sec_r increments; from 9 it goes to 0 and carries.
    - sec_l goes 5 -> 0 and carries.
    - min_r goes 9 -> 0 and carries.
    - min_l goes 5 -> 0.
  - 59:59 plus one tick gives 00:00. No overflow flag; counting continues.
- Adjust:
  - Applies only in ADJUST and on tick_2hz.
  - The field chosen by sel increments by 1 as a two-digit BCD value 00..59. From 59 it goes to 00.
  - No carry into the other field.
  - tick_1hz is ignored in ADJUST and PAUSED. tick_2hz is ignored outside ADJUST.
- Priority within one clk:
  - clear_ev takes precedence over any tick: digits are 0 after that edge.
  - If pause_ev and tick_1hz arrive together, the tick is evaluated against the current registered state. It counts if the state is RUN, and the state toggles on the same edge.
  - If adj rises together with tick_1hz while in RUN, the tick still counts and the state becomes ADJUST.
- sel changing mid-ADJUST takes effect on the next tick_2hz. The previously adjusted field keeps its value.
- rst_n asserted mid-count or mid-adjust returns to the reset values immediately. A button held through reset release produces no event until it is released and pressed again.

Test Plan:
1. Reset, then press pause_btn, then apply 61 tick_1hz pulses -> display 01:01, running=1. pause_btn event arrives exactly SYNC_STAGES+1 clks after the press.
2. Preload 59:58 via adjust, exit adjust, press pause, apply 3 ticks -> 59:59, 00:00, 00:01, each 1 clk after its tick.
3. In RUN at 00:07, press pause, apply 5 ticks -> stays 00:07, running=0. Press pause again, apply 1 tick -> 00:08.
4. adj=1, sel=0, apply 61 tick_2hz -> seconds 59 then 00 then 01, minutes unchanged 00. Switch sel=1, apply 2 ticks -> 02:01. Drop adj -> PAUSED, running=0.
5. In RUN at 12:34, assert reset_btn and pause_btn on the same clk as a tick_1hz arrives at the event stage -> digits 00:00, state PAUSED. Hold reset_btn for 50 clks -> only one clear event.
6. Assert rst_n=0 asynchronously mid-count at 03:45 (between clk edges) -> outputs go to 00:00 and running=0 without waiting for clk. After release, tick_1hz pulses are ignored until a pause_btn press.
